// File: rtl/nibble_serial_subtractor.sv
// Serial WIDTH-bit subtractor (a - b), one 4-bit CLA slice per clock; done pulses N edges after accept.
// start is honoured only while ready (IDLE); requests in RUN/DONE are dropped, never queued.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             ovf
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_r, nb_r, diff_r, diff_next;
  logic [IW-1:0]    idx;
  logic             carry, a_sign, b_sign;
  logic             accept, last;
  logic [3:0]       sa, sb, p, g, sum;
  logic             c1, c2, c3, cout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        ready  = 1'b1;
        accept = start;
        if (start) state_next = RUN;
      end
      RUN: begin
        last = (idx == LAST);
        if (idx == LAST) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One CLA slice: internal carries from P/G, slice carry-out via group P/G.
  always_comb begin
    sa   = a_r[{idx, 2'b00} +: 4];
    sb   = nb_r[{idx, 2'b00} +: 4];
    p    = sa ^ sb;
    g    = sa & sb;
    c1   = g[0] | (p[0] & carry);
    c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    cout = (g[3] | (g[2] & p[3]) | (g[1] & p[3] & p[2]) | (g[0] & p[3] & p[2] & p[1]))
         | ((&p) & carry);
    sum  = p ^ {c3, c2, c1, carry};
    diff_next = diff_r;
    diff_next[{idx, 2'b00} +: 4] = sum;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r        <= '0;
      nb_r       <= '0;
      diff_r     <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      a_sign     <= 1'b0;
      b_sign     <= 1'b0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
      ovf        <= 1'b0;
    end else if (accept) begin
      a_r    <= a;
      nb_r   <= ~b;
      carry  <= 1'b1;
      idx    <= '0;
      a_sign <= a[WIDTH-1];
      b_sign <= b[WIDTH-1];
    end else if (state == RUN) begin
      diff_r <= diff_next;
      carry  <= cout;
      if (last) begin
        // Flags come from the fully assembled result on the final slice edge.
        borrow_out <= ~cout;
        zero       <= ~|diff_next;
        ovf        <= (a_sign ^ b_sign) & (diff_next[WIDTH-1] ^ a_sign);
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

  assign diff = diff_r;

endmodule
